// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: restoring 16/8 unsigned divider, one quotient bit per clock with start/done_flag handshake
module seq_divider_16by8 (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [15:0] dataa,
  input  logic [7:0]  datab,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        done_flag,
  output logic        busy,
  output logic        div_by_zero
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic [15:0] dvd;
  logic [7:0]  dvs, pr, pr_n;
  logic [8:0]  shifted;
  logic [3:0]  count;
  logic        ge, last, accept;
  // dvd shifts dividend bits out the top and collects quotient bits at the bottom
  always_comb begin
    shifted = {pr, dvd[15]};
    ge      = shifted >= {1'b0, dvs};
    pr_n    = ge ? 8'(shifted - {1'b0, dvs}) : shifted[7:0];
    last    = count == 4'd15;
    accept  = state == IDLE && start;
    state_n = state == IDLE ? ((start && datab != 8'd0) ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      pr          <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done_flag   <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state     <= state_n;
      done_flag <= 1'b0;
      if (accept && datab == 8'd0) begin
        quotient    <= 16'hFFFF;
        remainder   <= dataa[7:0];
        div_by_zero <= 1'b1;
        done_flag   <= 1'b1;
      end else if (accept) begin
        dvd         <= dataa;
        dvs         <= datab;
        pr          <= '0;
        count       <= '0;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
      end else if (state == CALC) begin
        pr    <= pr_n;
        dvd   <= {dvd[14:0], ge};
        count <= count + 4'd1;
        if (last) begin
          quotient  <= {dvd[14:0], ge};
          remainder <= pr_n;
          done_flag <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb_seq_divider_16by8: randomized and directed checks of the divider against plain a/b, a%b arithmetic
module tb_seq_divider_16by8;
  logic        clk = 1'b0, reset_a = 1'b1, start = 1'b0;
  logic [15:0] dataa = '0;
  logic [7:0]  datab = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag, busy, div_by_zero;
  int tests = 0, fails = 0;

  seq_divider_16by8 dut (
    .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
    .quotient(quotient), .remainder(remainder), .done_flag(done_flag),
    .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one operation: measures latency, busy cycles and output stability, then checks the result
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input bit abuse);
    int k, bc;
    logic [15:0] pq;
    logic [7:0] prm;
    bit held;
    @(negedge clk);
    dataa = a; datab = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; bc = 0; held = 1'b1; pq = quotient; prm = remainder;
    if (b != 8'd0) chk("dbz_clear", 32'(div_by_zero), 32'd0);
    while (!done_flag && k < 40) begin
      bc += int'(busy);
      held &= (quotient === pq) && (remainder === prm);
      if (abuse) begin
        start = (k == 5);
        if (k == 5) begin dataa = 16'($urandom); datab = 8'($urandom); end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", 32'(k), b == 8'd0 ? 32'd1 : 32'd17);
    chk("busy_cycles", 32'(bc), b == 8'd0 ? 32'd0 : 32'd16);
    chk("hold", 32'(held), 32'd1);
    chk("quotient", 32'(quotient), b == 8'd0 ? 32'hFFFF : 32'(a / b));
    chk("remainder", 32'(remainder), b == 8'd0 ? 32'(a[7:0]) : 32'(a % b));
    chk("dbz", 32'(div_by_zero), 32'(b == 8'd0));
    @(negedge clk);
    chk("done_pulse", 32'(done_flag), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] qa [4];
    logic [7:0]  qb [4];
    int k;
    logic [7:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_flags", {29'd0, done_flag, busy, div_by_zero}, 32'd0);
    reset_a = 1'b0;

    do_div(16'd756, 8'd6, 1'b0);
    do_div(16'd65535, 8'd255, 1'b0);
    do_div(16'd65535, 8'd1, 1'b0);
    do_div(16'd5, 8'd200, 1'b0);
    do_div(16'd1000, 8'd7, 1'b0);
    do_div(16'd7400, 8'd37, 1'b0);
    do_div(16'h1234, 8'd0, 1'b0);
    do_div(16'd20, 8'd3, 1'b0);
    do_div(16'd50000, 8'd99, 1'b1);

    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom); y = 8'($urandom_range(1, 255));
      do_div(16'(x * y), y, 1'b0);
    end
    for (int i = 0; i < 500; i++)
      do_div(16'($urandom), (i % 50 == 0) ? 8'd0 : 8'($urandom), 1'b0);

    // start held high: a new operand pair is presented after each accept
    for (int i = 0; i < 4; i++) begin
      qa[i] = 16'($urandom); qb[i] = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    dataa = qa[0]; datab = qb[0]; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin dataa = qa[i+1]; datab = qb[i+1]; end
      k = 1;
      while (!done_flag && k < 40) begin @(negedge clk); k++; end
      if (i == 3) start = 1'b0;
      chk("bb_period", 32'(k), 32'd17);
      chk("bb_q", 32'(quotient), 32'(qa[i] / qb[i]));
      chk("bb_r", 32'(remainder), 32'(qa[i] % qb[i]));
    end
    repeat (20) @(negedge clk);
    chk("bb_stop", {30'd0, busy, done_flag}, 32'd0);

    // asynchronous reset part way through a division
    @(negedge clk);
    dataa = 16'd1000; datab = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset_a = 1'b1;
    #1;
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    chk("arst_flags", {29'd0, done_flag, busy, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    k = 0;
    repeat (25) begin @(negedge clk); k += int'(done_flag | busy); end
    chk("arst_no_done", 32'(k), 32'd0);
    do_div(16'd100, 8'd10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_divider_16by8.md
Name: seq_divider_16by8

Overview:
- Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing a 16-bit quotient and an 8-bit remainder.
- Computes one quotient bit per clock using the shift/subtract datapath.
- It is the inverse companion to the 8x8 sequential multiplier. Results of the divider must round-trip multiplier products, e.g. product8x8 / datab = dataa, remainder 0.
- Sits beside the multiplier under the same control/top level and uses the same start/done_flag handshake.

Parameters:
- None. Widths are fixed at 16/8 to pair with the 8x8 multiplier datapath.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_a  input  1  asynchronous, active-high reset.
- start  input  1  request pulse, sampled on the rising edge of clk.
- dataa  input  16  unsigned dividend, sampled when start is accepted.
- datab  input  8  unsigned divisor, sampled when start is accepted.
- quotient  output  16  registered quotient.
- remainder  output  8  registered remainder.
- done_flag  output  1  one-cycle pulse marking quotient/remainder valid.
- busy  output  1  high while a division is in progress.
- div_by_zero  output  1  set with done_flag when datab was 0; held until the next accepted start.

Behaviour:
- Reset (reset_a=1, asynchronous, any state): state=IDLE, count=0, quotient=0, remainder=0, done_flag=0, busy=0, div_by_zero=0. Internal registers are cleared. A reset mid-division abandons the operation, and no done_flag is produced.
- States: IDLE, CALC.
- IDLE, start=0: remain in IDLE; outputs hold their last values; done_flag=0.
- IDLE, start=1 at edge N, datab!=0:
  - Capture dataa into the dividend shift register.
  - Capture datab into the divisor register.
  - Clear the 9-bit partial remainder, set count=0, busy=1, div_by_zero=0.
  - Go to CALC.
- IDLE, start=1 at edge N, datab==0:
  - At edge N set quotient=16'hFFFF, remainder=dataa[7:0], div_by_zero=1, done_flag=1.
  - Stay in IDLE; busy stays 0.
- CALC, each edge:
  - pr = {pr[7:0], dvd[15]}; dvd shifts left by 1.
  - If pr >= {1'b0, divisor}: pr = pr - divisor and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - count increments.
- Partial remainder width: 9 bits, so no overflow is possible. Remainder is always < divisor and fits in 8 bits.
- At the 16th CALC edge (edge N+16):
  - Load quotient and remainder from the final values.
  - done_flag=1, busy=0, state returns to IDLE.
- done_flag timing: high for exactly the one cycle following the completing edge, then 0.
- Latency: 16 cycles from the accepting edge to done_flag for a normal divide; 0 extra cycles for divide-by-zero.
- start while busy (CALC): ignored; the in-flight operation is unaffected.
- start=1 in the cycle done_flag=1 (already in IDLE): accepted as a new operation. Outputs keep the previous result until the new completion.
- dataa/datab changing during CALC: no effect (operands registered).
- Quotient/remainder outputs change only on completion or reset. They must not show intermediate values.
- Continuous start held high: back-to-back operations every 17 cycles (1 accept edge + 16 CALC edges) for a nonzero divisor.

Test Plan:
- 756/6: dataa=16'd756, datab=8'd6, one-cycle start → after 16 cycles done_flag=1 for one cycle; quotient=126, remainder=0, div_by_zero=0; busy high for exactly 16 cycles.
- Boundary values:
  - 65535/255 → quotient=257, remainder=0.
  - 65535/1 → quotient=65535, remainder=0.
  - 5/200 → quotient=0, remainder=5.
  - 1000/7 → quotient=142, remainder=6.
- Multiplier round-trip: dataa=7400 (200×37), datab=37 → quotient=200, remainder=0. Also check a random sweep of 500 (a,b) pairs against the a/b and a%b reference model.
- Divide by zero: dataa=16'h1234, datab=0, start → next cycle quotient=16'hFFFF, remainder=8'h34, div_by_zero=1, done_flag one cycle, busy never asserts. A following 20/3 clears div_by_zero at accept and yields quotient=6, remainder=2.
- Handshake abuse:
  - start pulsed at cycle 5 of CALC with different operands → ignored; the original result appears at cycle 16.
  - start held high continuously → results every 17 cycles, each matching its sampled operands.
- Reset mid-operation: assert reset_a asynchronously (between clock edges) at cycle 8 of CALC → all outputs 0 immediately; no done_flag after release; a subsequent 100/10 returns quotient=10, remainder=0.
